// File: rtl/rvv_issue_bridge.sv
// Scalar-side bridge to the vector core: in-order insn queue with ID allocation,
// issue, in-order commit grant, done/illegal collection, in-order retire and flush.
package rvv_issue_bridge_pkg;
    localparam int unsigned InsnW = 32;
    localparam int unsigned XlenW = 32;
    localparam int unsigned IdW   = 2;
    localparam int unsigned Depth = 2 ** IdW;

    typedef logic [XlenW-1:0] xlen_t;
    typedef logic [IdW-1:0]   insn_id_t;

    typedef struct packed {
        logic [7:0] vtype;
        logic [7:0] vl;
    } vec_context_t;

    typedef struct packed {
        logic [InsnW-1:0] insn;
        xlen_t            scalar;
        vec_context_t     ctx;
    } entry_t;
endpackage

module rvv_issue_bridge
    import rvv_issue_bridge_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [InsnW-1:0] disp_insn_i,
    input  xlen_t            disp_scalar_i,
    input  vec_context_t     disp_ctx_i,
    input  logic             nonspec_i,
    input  logic             flush_i,
    output logic             vec_valid_o,
    input  logic             vec_ready_i,
    output logic [InsnW-1:0] vec_insn_o,
    output insn_id_t         vec_insn_id_o,
    output xlen_t            vec_scalar_o,
    output vec_context_t     vec_ctx_o,
    output logic             vec_flush_o,
    output logic             vec_can_commit_o,
    output insn_id_t         vec_can_commit_id_o,
    input  logic             vec_done_i,
    input  insn_id_t         vec_done_id_i,
    input  logic             vec_illegal_i,
    output logic             retire_valid_o,
    output insn_id_t         retire_id_o,
    output logic             retire_illegal_o,
    output logic             err_o
);
    localparam int unsigned PtrW = IdW + 1;
    typedef logic [PtrW-1:0] ptr_t;

    ptr_t             head_q, cptr_q, iptr_q, tail_q;
    ptr_t             head_n, cptr_n, iptr_n, tail_n;
    logic [Depth-1:0] issued_q, committed_q, done_q, illegal_q;
    logic [Depth-1:0] issued_n, committed_n, done_n, illegal_n;
    logic             err_q, err_n, flush_q;
    logic             commit_q, retire_q, retire_ill_q;
    insn_id_t         commit_id_q, retire_id_q;
    entry_t           entry_q [Depth];
    entry_t           iss_entry;

    ptr_t             count;
    logic             disp_fire, issue_fire, commit_fire, retire_fire, done_ok;
    insn_id_t         head_idx, cptr_idx, iptr_idx, tail_idx;

    assign head_idx = head_q[IdW-1:0];
    assign cptr_idx = cptr_q[IdW-1:0];
    assign iptr_idx = iptr_q[IdW-1:0];
    assign tail_idx = tail_q[IdW-1:0];

    // Handshakes and next state; pointer wrap bit distinguishes full from empty
    always_comb begin
        head_n      = head_q;
        cptr_n      = cptr_q;
        iptr_n      = iptr_q;
        tail_n      = tail_q;
        issued_n    = issued_q;
        committed_n = committed_q;
        done_n      = done_q;
        illegal_n   = illegal_q;
        err_n       = err_q;

        count        = tail_q - head_q;
        disp_ready_o = (count < PtrW'(Depth)) && !flush_i;
        disp_fire    = disp_valid_i && disp_ready_o;
        vec_valid_o  = (iptr_q != tail_q) && !flush_i && !flush_q;
        issue_fire   = vec_valid_o && vec_ready_i;
        commit_fire  = (cptr_q != iptr_q) && nonspec_i && !flush_i;
        retire_fire  = (head_q != cptr_q) && done_q[head_idx] && committed_q[head_idx];
        done_ok      = issued_q[vec_done_id_i];

        if (disp_fire) begin
            issued_n[tail_idx]    = 1'b0;
            committed_n[tail_idx] = 1'b0;
            done_n[tail_idx]      = 1'b0;
            illegal_n[tail_idx]   = 1'b0;
            tail_n                = tail_q + PtrW'(1);
        end
        if (issue_fire) begin
            issued_n[iptr_idx] = 1'b1;
            iptr_n             = iptr_q + PtrW'(1);
        end
        if (commit_fire) begin
            committed_n[cptr_idx] = 1'b1;
            cptr_n                = cptr_q + PtrW'(1);
        end
        if (vec_done_i) begin
            if (done_ok) begin
                done_n[vec_done_id_i]    = 1'b1;
                illegal_n[vec_done_id_i] = vec_illegal_i;
            end else begin
                err_n = 1'b1;
            end
        end
        if (retire_fire) begin
            issued_n[head_idx]    = 1'b0;
            committed_n[head_idx] = 1'b0;
            done_n[head_idx]      = 1'b0;
            illegal_n[head_idx]   = 1'b0;
            head_n                = head_q + PtrW'(1);
        end
        // Live uncommitted entries are exactly the ones flush drops; free entries are already clear
        if (flush_i) begin
            tail_n    = cptr_q;
            iptr_n    = cptr_q;
            issued_n  = issued_n & committed_q;
            done_n    = done_n & committed_q;
            illegal_n = illegal_n & committed_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q       <= '0;
            cptr_q       <= '0;
            iptr_q       <= '0;
            tail_q       <= '0;
            issued_q     <= '0;
            committed_q  <= '0;
            done_q       <= '0;
            illegal_q    <= '0;
            err_q        <= 1'b0;
            flush_q      <= 1'b0;
            commit_q     <= 1'b0;
            commit_id_q  <= '0;
            retire_q     <= 1'b0;
            retire_id_q  <= '0;
            retire_ill_q <= 1'b0;
        end else begin
            head_q      <= head_n;
            cptr_q      <= cptr_n;
            iptr_q      <= iptr_n;
            tail_q      <= tail_n;
            issued_q    <= issued_n;
            committed_q <= committed_n;
            done_q      <= done_n;
            illegal_q   <= illegal_n;
            err_q       <= err_n;
            flush_q     <= flush_i;
            commit_q    <= commit_fire;
            retire_q    <= retire_fire;
            if (commit_fire) begin
                commit_id_q <= cptr_idx;
            end
            if (retire_fire) begin
                retire_id_q  <= head_idx;
                retire_ill_q <= illegal_q[head_idx];
            end
        end
    end

    // Payload storage needs no reset: it is only observed behind vec_valid_o
    always_ff @(posedge clk_i) begin
        if (disp_fire) begin
            entry_q[tail_idx] <= '{insn: disp_insn_i, scalar: disp_scalar_i, ctx: disp_ctx_i};
        end
    end

    always_comb begin
        iss_entry     = entry_q[iptr_idx];
        vec_insn_o    = vec_valid_o ? iss_entry.insn   : '0;
        vec_scalar_o  = vec_valid_o ? iss_entry.scalar : '0;
        vec_ctx_o     = vec_valid_o ? iss_entry.ctx    : '0;
        vec_insn_id_o = vec_valid_o ? iptr_idx         : '0;
    end

    assign vec_flush_o         = flush_q;
    assign vec_can_commit_o    = commit_q;
    assign vec_can_commit_id_o = commit_id_q;
    assign retire_valid_o      = retire_q;
    assign retire_id_o         = retire_id_q;
    assign retire_illegal_o    = retire_ill_q;
    assign err_o               = err_q;

endmodule

// File: tb/tb_rvv_issue_bridge.sv
// Directed bench for rvv_issue_bridge against a program-order queue model of the bridge.
module tb_rvv_issue_bridge;
    import rvv_issue_bridge_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         disp_valid_i, disp_ready_o;
    logic [31:0]  disp_insn_i;
    xlen_t        disp_scalar_i;
    vec_context_t disp_ctx_i;
    logic         nonspec_i, flush_i;
    logic         vec_valid_o, vec_ready_i;
    logic [31:0]  vec_insn_o;
    insn_id_t     vec_insn_id_o;
    xlen_t        vec_scalar_o;
    vec_context_t vec_ctx_o;
    logic         vec_flush_o, vec_can_commit_o;
    insn_id_t     vec_can_commit_id_o;
    logic         vec_done_i;
    insn_id_t     vec_done_id_i;
    logic         vec_illegal_i;
    logic         retire_valid_o;
    insn_id_t     retire_id_o;
    logic         retire_illegal_o, err_o;

    rvv_issue_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_insn_i(disp_insn_i), .disp_scalar_i(disp_scalar_i), .disp_ctx_i(disp_ctx_i),
        .nonspec_i(nonspec_i), .flush_i(flush_i),
        .vec_valid_o(vec_valid_o), .vec_ready_i(vec_ready_i),
        .vec_insn_o(vec_insn_o), .vec_insn_id_o(vec_insn_id_o),
        .vec_scalar_o(vec_scalar_o), .vec_ctx_o(vec_ctx_o),
        .vec_flush_o(vec_flush_o), .vec_can_commit_o(vec_can_commit_o),
        .vec_can_commit_id_o(vec_can_commit_id_o),
        .vec_done_i(vec_done_i), .vec_done_id_i(vec_done_id_i), .vec_illegal_i(vec_illegal_i),
        .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o),
        .retire_illegal_o(retire_illegal_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        insn_id_t     id;
        logic [31:0]  insn;
        xlen_t        scalar;
        vec_context_t ctx;
        bit           issued, committed, done, illegal;
    } m_ent_t;

    m_ent_t      mq[$];
    int unsigned m_head;
    bit          e_commit, e_retire, e_ret_ill, e_flush, e_err;
    insn_id_t    e_commit_id, e_retire_id;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_unissued();
        for (int i = 0; i < mq.size(); i++) if (!mq[i].issued) return i;
        return -1;
    endfunction

    function automatic int first_uncommitted();
        for (int i = 0; i < mq.size(); i++) if (!mq[i].committed) return i;
        return -1;
    endfunction

    function automatic int find_id(input insn_id_t id);
        for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_head = 0;
        e_commit = 0; e_retire = 0; e_ret_ill = 0; e_flush = 0; e_err = 0;
        e_commit_id = '0; e_retire_id = '0;
    endtask

    // Compares every DUT output against what the model state and current inputs require
    task automatic compare();
        int  u;
        bit  exp_valid;
        u = first_unissued();
        exp_valid = (u >= 0) && !flush_i && !e_flush;
        chk("disp_ready", 64'(disp_ready_o), 64'((mq.size() < 4) && !flush_i));
        chk("vec_valid", 64'(vec_valid_o), 64'(exp_valid));
        if (exp_valid && vec_valid_o) begin
            chk("issue_id", 64'(vec_insn_id_o), 64'(mq[u].id));
            chk("issue_insn", 64'(vec_insn_o), 64'(mq[u].insn));
            chk("issue_scalar", 64'(vec_scalar_o), 64'(mq[u].scalar));
            chk("issue_ctx", 64'(vec_ctx_o), 64'(mq[u].ctx));
        end
        chk("vec_flush", 64'(vec_flush_o), 64'(e_flush));
        chk("can_commit", 64'(vec_can_commit_o), 64'(e_commit));
        if (e_commit) chk("can_commit_id", 64'(vec_can_commit_id_o), 64'(e_commit_id));
        chk("retire_valid", 64'(retire_valid_o), 64'(e_retire));
        if (e_retire) begin
            chk("retire_id", 64'(retire_id_o), 64'(e_retire_id));
            chk("retire_illegal", 64'(retire_illegal_o), 64'(e_ret_ill));
        end
        chk("err", 64'(err_o), 64'(e_err));
    endtask

    // Advances the model across one clock edge using the inputs currently applied
    task automatic model_tick();
        int       sz, u, c, d;
        bit       d_fire, i_fire, c_fire, r_fire, ok;
        insn_id_t tail_id;
        m_ent_t   e;
        sz      = mq.size();
        tail_id = insn_id_t'(m_head + unsigned'(sz));
        d_fire  = disp_valid_i && (sz < 4) && !flush_i;
        u       = first_unissued();
        i_fire  = (u >= 0) && !flush_i && !e_flush && vec_ready_i;
        c       = first_uncommitted();
        c_fire  = (c >= 0) && mq[c].issued && nonspec_i && !flush_i;
        r_fire  = (sz > 0) && mq[0].committed && mq[0].done;
        e_retire = r_fire;
        if (r_fire) begin
            e_retire_id = mq[0].id;
            e_ret_ill   = mq[0].illegal;
        end
        d  = find_id(vec_done_id_i);
        ok = (d >= 0) && mq[d].issued;
        if (vec_done_i && !ok) e_err = 1;
        if (vec_done_i && ok) begin
            e = mq[d]; e.done = 1; e.illegal = vec_illegal_i; mq[d] = e;
        end
        if (i_fire) begin
            e = mq[u]; e.issued = 1; mq[u] = e;
        end
        e_commit = c_fire;
        if (c_fire) begin
            e = mq[c]; e.committed = 1; mq[c] = e;
            e_commit_id = e.id;
        end
        e_flush = flush_i;
        if (flush_i) begin
            while (mq.size() > 0 && !mq[mq.size()-1].committed) void'(mq.pop_back());
        end
        if (r_fire) begin
            void'(mq.pop_front());
            m_head++;
        end
        if (d_fire) begin
            e = '{id: tail_id, insn: disp_insn_i, scalar: disp_scalar_i, ctx: disp_ctx_i,
                  issued: 0, committed: 0, done: 0, illegal: 0};
            mq.push_back(e);
        end
    endtask

    task automatic settle();
        #1;
        compare();
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        disp_valid_i = 0; disp_insn_i = '0; disp_scalar_i = '0; disp_ctx_i = '0;
        nonspec_i = 0; flush_i = 0; vec_ready_i = 0;
        vec_done_i = 0; vec_done_id_i = '0; vec_illegal_i = 0;
    endtask

    task automatic disp(input logic [31:0] insn);
        disp_valid_i  = 1;
        disp_insn_i   = insn;
        disp_scalar_i = insn ^ 32'h5555_AAAA;
        disp_ctx_i    = {insn[7:0], insn[15:8]};
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset(input string tag);
        idle();
        rst_ni = 0;
        #1;
        model_reset();
        compare();
        chk({tag, "_rst_ready"}, 64'(disp_ready_o), 64'(1));
        chk({tag, "_rst_valid"}, 64'(vec_valid_o), 64'(0));
        chk({tag, "_rst_commit"}, 64'(vec_can_commit_o), 64'(0));
        chk({tag, "_rst_retire"}, 64'(retire_valid_o), 64'(0));
        chk({tag, "_rst_err"}, 64'(err_o), 64'(0));
        chk({tag, "_rst_insn"}, 64'(vec_insn_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1;
    endtask

    insn_id_t exp_order [5];
    int       issue_n, ret_cnt;
    bit       accepted5, pend;
    insn_id_t pend_id;

    initial begin
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        do_reset("init");

        // Single insn end to end
        disp(32'h0200_7057); vec_ready_i = 1; step();
        disp_valid_i = 0; settle();
        chk("t1_issue_valid", 64'(vec_valid_o), 64'(1));
        chk("t1_issue_id", 64'(vec_insn_id_o), 64'(0));
        chk("t1_issue_insn", 64'(vec_insn_o), 64'h0200_7057);
        tick();
        nonspec_i = 1; vec_done_i = 1; vec_done_id_i = 2'd0; step();
        vec_done_i = 0; settle();
        chk("t1_commit", 64'(vec_can_commit_o), 64'(1));
        chk("t1_commit_id", 64'(vec_can_commit_id_o), 64'(0));
        tick();
        settle();
        chk("t1_retire", 64'(retire_valid_o), 64'(1));
        chk("t1_retire_id", 64'(retire_id_o), 64'(0));
        chk("t1_retire_ill", 64'(retire_illegal_o), 64'(0));
        tick();
        nonspec_i = 0; step(); step();

        // Fill the queue, then drain; the 5th dispatch waits for the first retire
        do_reset("t2");
        for (int k = 0; k < 5; k++) begin
            disp(32'hA000_0000 + 32'(k));
            settle();
            if (k == 4) chk("t2_full", 64'(disp_ready_o), 64'(0));
            tick();
        end
        vec_ready_i = 1; nonspec_i = 1;
        issue_n = 0; ret_cnt = 0; accepted5 = 0; pend = 0; pend_id = '0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            vec_done_i    = pend;
            vec_done_id_i = pend_id;
            disp_valid_i  = !accepted5;
            settle();
            if (retire_valid_o) ret_cnt++;
            if (disp_valid_i && disp_ready_o) begin
                chk("t2_accept_on_retire", 64'(retire_valid_o), 64'(1));
                chk("t2_accept_first_retire", 64'(ret_cnt), 64'(1));
                accepted5 = 1;
            end
            pend = vec_valid_o && vec_ready_i;
            if (pend) begin
                pend_id = vec_insn_id_o;
                if (issue_n < 5) chk("t2_issue_order", 64'(vec_insn_id_o), 64'(exp_order[issue_n]));
                issue_n++;
            end
            tick();
        end
        chk("t2_issue_count", 64'(issue_n), 64'(5));
        chk("t2_retire_count", 64'(ret_cnt), 64'(5));

        // Done arrives long before commit
        do_reset("t3");
        disp(32'h0200_7057); vec_ready_i = 1; step();
        disp_valid_i = 0; settle();
        chk("t3_issue_id", 64'(vec_insn_id_o), 64'(0));
        tick();
        vec_done_i = 1; vec_done_id_i = 2'd0; vec_illegal_i = 1; step();
        vec_done_i = 0; vec_illegal_i = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t3_no_retire", 64'(retire_valid_o), 64'(0));
            chk("t3_no_commit", 64'(vec_can_commit_o), 64'(0));
            tick();
        end
        nonspec_i = 1; step();
        settle();
        chk("t3_commit", 64'(vec_can_commit_o), 64'(1));
        tick();
        settle();
        chk("t3_retire", 64'(retire_valid_o), 64'(1));
        chk("t3_retire_id", 64'(retire_id_o), 64'(0));
        chk("t3_retire_ill", 64'(retire_illegal_o), 64'(1));
        tick();
        nonspec_i = 0; step();

        // Flush keeps committed ID 0 and drops IDs 1,2
        do_reset("t4");
        vec_ready_i = 1;
        disp(32'hB000_0000); step();
        disp(32'hB000_0001); step();
        disp(32'hB000_0002); nonspec_i = 1; step();
        disp_valid_i = 0; nonspec_i = 0; step();
        disp(32'hB000_0003); flush_i = 1; nonspec_i = 1; settle();
        chk("t4_ready_in_flush", 64'(disp_ready_o), 64'(0));
        tick();
        disp_valid_i = 0; flush_i = 0; nonspec_i = 0; settle();
        chk("t4_flush_pulse", 64'(vec_flush_o), 64'(1));
        tick();
        vec_done_i = 1; vec_done_id_i = 2'd0; step();
        vec_done_i = 0; step();
        settle();
        chk("t4_retire_id0", 64'(retire_valid_o), 64'(1));
        chk("t4_retire_id", 64'(retire_id_o), 64'(0));
        tick();
        disp(32'hB000_0005); step();
        disp_valid_i = 0; settle();
        chk("t4_next_id", 64'(vec_insn_id_o), 64'(1));
        tick();
        vec_ready_i = 0; disp(32'hB000_0006); step();
        disp_valid_i = 0; flush_i = 1; settle();
        chk("t4_valid_forced_flush", 64'(vec_valid_o), 64'(0));
        tick();
        flush_i = 0; vec_ready_i = 1; settle();
        chk("t4_valid_forced_after", 64'(vec_valid_o), 64'(0));
        tick();
        step();

        // Done for a free entry is dropped and flags a sticky error
        do_reset("t5");
        vec_done_i = 1; vec_done_id_i = 2'd3; step();
        vec_done_i = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t5_err_sticky", 64'(err_o), 64'(1));
            chk("t5_no_retire", 64'(retire_valid_o), 64'(0));
            tick();
        end

        // Reset with two insns in flight; late reports only raise err_o
        do_reset("t6a");
        vec_ready_i = 1;
        disp(32'hC000_0000); step();
        disp(32'hC000_0001); step();
        disp_valid_i = 0; nonspec_i = 1; step();
        vec_done_i = 1; vec_done_id_i = 2'd0; step();
        do_reset("t6");
        vec_done_i = 1; vec_done_id_i = 2'd1; step();
        vec_done_i = 0; settle();
        chk("t6_late_err", 64'(err_o), 64'(1));
        chk("t6_no_retire", 64'(retire_valid_o), 64'(0));
        tick();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
